vol_ramp_ctrl: RTL
==================

VOL_RAMP_CTRL -- requirements
Module: vol_ramp_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH_IN, default 8, meaning number of mixer input channels.
REQ-002 SHALL have parameter NUM_CH_IN_LOG2, default 3, meaning channel index width.
REQ-003 SHALL have parameter VOL_WIDTH, default 32, meaning unsigned volume width, 8.24 fixed point (32'h01_000000 = unity).
REQ-004 SHALL have port clk, input, 1 bit, meaning system clock (49.152 MHz).
REQ-005 SHALL have port rst, input, 1 bit, meaning synchronous, active-high reset.
REQ-006 SHALL have port tick_i, input, 1 bit, meaning ramp-update strobe, one pulse per sample period.
REQ-007 SHALL have port wr_i, input, 1 bit, meaning channel configuration write request.
REQ-008 SHALL have port wr_ch_i, input, NUM_CH_IN_LOG2 bits, meaning channel index of the write.
REQ-009 SHALL have port wr_target_i, input, VOL_WIDTH bits, meaning target volume of the write.
REQ-010 SHALL have port wr_step_i, input, VOL_WIDTH bits, meaning per-tick step magnitude; 0 means jump.
REQ-011 SHALL have port wr_ack_o, output, 1 bit, meaning write accepted.
REQ-012 SHALL have port vol_o, output, NUM_CH_IN*VOL_WIDTH bits, meaning current volumes, channel n at [n*VOL_WIDTH +: VOL_WIDTH], feeding mixer vol_i.
REQ-013 SHALL have port ramping_o, output, NUM_CH_IN bits, meaning bit n high while cur[n] != target[n].
REQ-014 SHALL have port sweep_done_o, output, 1 bit, meaning one-cycle pulse on the last cycle of a sweep.
REQ-015 SHALL have port overrun_o, output, 1 bit, meaning one-cycle pulse when a tick is dropped.

Function
REQ-016 SHALL hold per-channel registers cur, target, step, all VOL_WIDTH bits.
REQ-017 SHALL implement FSM states IDLE and SWEEP; IDLE->SWEEP on tick_i or pending tick; SWEEP->IDLE after channel NUM_CH_IN-1 is processed with no pending tick.
REQ-018 SHALL in SWEEP process exactly one channel per clock, index 0 to NUM_CH_IN-1, so a sweep lasts NUM_CH_IN cycles.
REQ-019 SHALL compute for a processed channel: if cur<target, cur=min(cur+step,target); if cur>target, cur=max(cur-step,target); else unchanged; step=0 sets cur=target.
REQ-020 SHALL perform add/subtract at VOL_WIDTH+1 bits so the result never wraps past 0 or 2^VOL_WIDTH-1.
REQ-021 SHALL accept wr_i on any cycle, load target and step of wr_ch_i, and assert wr_ack_o exactly one cycle later for one cycle.
REQ-022 SHALL, when a write and a sweep update hit the same channel in the same cycle, apply the write and skip that channel's update for this sweep.
REQ-023 SHALL, on tick_i during SWEEP, set a single pending flag; the next sweep starts the cycle after sweep_done_o.
REQ-024 SHALL, on tick_i while pending is already set, drop the tick and pulse overrun_o in that cycle.
REQ-025 SHALL drive vol_o and ramping_o directly from registers; a cur update becomes visible the cycle after processing.

Reset
REQ-026 SHALL on rst set every cur and target to 32'h01_000000, every step to 0, the FSM to IDLE, and the pending flag to 0.
REQ-027 SHALL hold wr_ack_o, sweep_done_o, overrun_o and ramping_o at 0 while rst is high and in the first cycle after it.
REQ-028 SHALL, on rst asserted mid-sweep, abandon the sweep without finishing it and without pulsing sweep_done_o.

Configuration
REQ-029 SHALL, with VOL_RAMP_MUTE_EN defined, add input mute_i (NUM_CH_IN bits); a muted channel ramps toward 0 using its step, and on unmute ramps back to its stored target, which mute never modifies.
REQ-030 SHALL, without VOL_RAMP_MUTE_EN, omit mute_i and use target as the ramp goal for every channel.

Verification
REQ-031 SHALL cover: reset, no writes -> all vol_o lanes read 32'h01_000000, ramping_o=0.
REQ-032 SHALL cover: write ch2 target 0, step 32'h00_400000, then 4 ticks -> ch2 cur 0x00C00000, 0x00800000, 0x00400000, 0; ramping_o[2] clears after the 4th sweep.
REQ-033 SHALL cover: write ch5 target 32'hFFFF_FFF0, step 32'h8000_0000 -> cur 0x81000000, then 0xFFFFFFF0, with no wrap.
REQ-034 SHALL cover: tick_i at sweep cycles 1, 3 and 5 -> one pending sweep follows immediately; overrun_o pulses at cycles 3 and 5.
REQ-035 SHALL cover: write to ch3 in the same cycle as ch3 is processed -> new target loaded, cur[3] unchanged that sweep, wr_ack_o high the next cycle.
REQ-036 SHALL cover (with VOL_RAMP_MUTE_EN): ch0 at unity, step 32'h00_800000, mute 2 ticks -> cur 0; unmute 2 ticks -> cur 0x01000000.

Source files
------------

// File: rtl/vol_ramp_ctrl.sv
// Per-channel volume ramp engine: on each tick, sweeps channels 0..NUM_CH_IN-1 one per clock.
// Optional build macro VOL_RAMP_MUTE_EN adds mute_i; muted channels ramp toward zero.
module vol_ramp_ctrl #(
  parameter int NUM_CH_IN      = 8,
  parameter int NUM_CH_IN_LOG2 = 3,
  parameter int VOL_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick_i,
  input  logic                           wr_i,
  input  logic [NUM_CH_IN_LOG2-1:0]      wr_ch_i,
  input  logic [VOL_WIDTH-1:0]           wr_target_i,
  input  logic [VOL_WIDTH-1:0]           wr_step_i,
`ifdef VOL_RAMP_MUTE_EN
  input  logic [NUM_CH_IN-1:0]           mute_i,
`endif
  output logic                           wr_ack_o,
  output logic [NUM_CH_IN*VOL_WIDTH-1:0] vol_o,
  output logic [NUM_CH_IN-1:0]           ramping_o,
  output logic                           sweep_done_o,
  output logic                           overrun_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  // 8.24 fixed point: unity sits just above the fractional bits
  localparam logic [VOL_WIDTH-1:0]      UNITY   = {{(VOL_WIDTH-1){1'b0}}, 1'b1} << (VOL_WIDTH - 8);
  localparam logic [NUM_CH_IN_LOG2-1:0] LAST_CH = NUM_CH_IN_LOG2'(NUM_CH_IN - 1);

  logic [0:0]                r_state;
  logic [NUM_CH_IN_LOG2-1:0] r_ch;
  logic                      r_pending;
  logic                      r_wr_ack;
  logic                      w_in_sweep;
  logic                      w_last;
  logic                      w_pend_eff;

  assign w_in_sweep = (r_state == SWEEP);
  assign w_last     = w_in_sweep && (r_ch == LAST_CH);
  // A tick landing on the final sweep cycle counts as pending for the restart decision
  assign w_pend_eff = r_pending || (w_in_sweep && tick_i);

  assign overrun_o    = !rst && w_in_sweep && tick_i && r_pending;
  assign sweep_done_o = !rst && w_last;
  assign wr_ack_o     = r_wr_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_pending <= 1'b0;
      r_wr_ack  <= 1'b0;
    end else begin
      r_wr_ack <= wr_i;
      case (r_state)
        IDLE: begin
          if (tick_i || r_pending) begin
            r_state   <= SWEEP;
            r_ch      <= '0;
            r_pending <= 1'b0;
          end
        end
        default: begin
          if (w_last) begin
            r_ch      <= '0;
            r_pending <= 1'b0;
            if (!w_pend_eff) begin
              r_state <= IDLE;
            end
          end else begin
            r_ch <= r_ch + NUM_CH_IN_LOG2'(1);
            if (tick_i) begin
              r_pending <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH_IN; gi++) begin : g_ch
      logic [VOL_WIDTH-1:0] r_cur;
      logic [VOL_WIDTH-1:0] r_target;
      logic [VOL_WIDTH-1:0] r_step;
      logic                 r_ramp;
      logic [VOL_WIDTH-1:0] w_goal;
      logic [VOL_WIDTH-1:0] w_ramp;
      logic [VOL_WIDTH-1:0] w_cur_next;
      logic [VOL_WIDTH-1:0] w_target_next;
      logic [VOL_WIDTH:0]   w_sum;
      logic [VOL_WIDTH:0]   w_diff;
      logic                 w_wr;
      logic                 w_proc;

      assign w_wr   = wr_i && (wr_ch_i == NUM_CH_IN_LOG2'(gi));
      // A write to the channel being processed wins; its ramp step waits for the next sweep
      assign w_proc = w_in_sweep && (r_ch == NUM_CH_IN_LOG2'(gi)) && !w_wr;

`ifdef VOL_RAMP_MUTE_EN
      assign w_goal = mute_i[gi] ? '0 : r_target;
`else
      assign w_goal = r_target;
`endif

      assign w_sum  = {1'b0, r_cur} + {1'b0, r_step};
      assign w_diff = {1'b0, r_cur} - {1'b0, r_step};

      always_comb begin
        w_ramp = r_cur;
        if (r_step == '0) begin
          w_ramp = w_goal;
        end else if (r_cur < w_goal) begin
          w_ramp = (w_sum >= {1'b0, w_goal}) ? w_goal : w_sum[VOL_WIDTH-1:0];
        end else if (r_cur > w_goal) begin
          // borrow out of the extra bit means the step went below zero
          w_ramp = (w_diff[VOL_WIDTH] || (w_diff <= {1'b0, w_goal})) ? w_goal : w_diff[VOL_WIDTH-1:0];
        end
      end

      assign w_cur_next    = w_proc ? w_ramp : r_cur;
      assign w_target_next = w_wr ? wr_target_i : r_target;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cur    <= UNITY;
          r_target <= UNITY;
          r_step   <= '0;
          r_ramp   <= 1'b0;
        end else begin
          r_cur    <= w_cur_next;
          r_target <= w_target_next;
          if (w_wr) begin
            r_step <= wr_step_i;
          end
          r_ramp <= (w_cur_next != w_target_next);
        end
      end

      assign vol_o[gi*VOL_WIDTH +: VOL_WIDTH] = r_cur;
      assign ramping_o[gi]                    = r_ramp;
    end
  endgenerate

endmodule
